// File: rtl/axis_mux_dma_sink_sched_if.sv
// Command channel between the DMA sink scheduler and the stream multiplexer.
// Each command names the input stream, its beat count minus one, and whether it ends a transfer.
interface muxIntf #(
  parameter int CHAN_BITS = 2,
  parameter int BLEN_BITS = 10
);
  typedef struct packed {
    logic [CHAN_BITS-1:0] chan;
    logic [BLEN_BITS-1:0] len;
    logic                 last;
  } cmd_t;

  logic valid;
  logic ready;
  cmd_t data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/axis_mux_dma_sink_sched.sv
// Round-robin scheduler turning per-channel byte-length requests into mux beat commands.
// Define MUX_SCHED_SPLIT_EN to split long requests into bursts of at most MAX_BURST_BYTES.
module axis_mux_dma_sink_sched #(
  parameter int N_SPLIT_CHAN    = 4,
  parameter int MUX_DATA_BITS   = 512,
  parameter int MAX_BURST_BYTES = 4096,
  parameter int LEN_BITS        = 16
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [N_SPLIT_CHAN-1:0]                req_valid,
  output logic [N_SPLIT_CHAN-1:0]                req_ready,
  input  logic [N_SPLIT_CHAN-1:0][LEN_BITS-1:0]  req_len,
  input  logic [N_SPLIT_CHAN-1:0]                req_last,
  muxIntf.m                                      mux
);
  localparam int BEAT_BYTES = MUX_DATA_BITS / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int BLEN_BITS  = LEN_BITS - BEAT_SHIFT;
  localparam int REM_BITS   = BLEN_BITS + 1;
  localparam int CHAN_BITS  = $clog2(N_SPLIT_CHAN);
  localparam int BURST_BEATS = MAX_BURST_BYTES / BEAT_BYTES;

  if (N_SPLIT_CHAN < 2 || BURST_BEATS < 1 || (MAX_BURST_BYTES % BEAT_BYTES) != 0 ||
      (BURST_BEATS & (BURST_BEATS - 1)) != 0) begin : g_bad_params
    $error("axis_mux_dma_sink_sched: illegal parameter combination");
  end

`ifdef MUX_SCHED_SPLIT_EN
  localparam logic [REM_BITS-1:0] MAX_BEATS = REM_BITS'(BURST_BEATS);
`endif

  typedef enum logic {ST_ARB, ST_ISSUE} state_t;

  state_t                 state, next_state;
  logic [N_SPLIT_CHAN-1:0] hv;
  logic [N_SPLIT_CHAN-1:0] lst;
  logic [REM_BITS-1:0]    rem [N_SPLIT_CHAN];
  logic [REM_BITS-1:0]    ceil_beats [N_SPLIT_CHAN];
  logic [CHAN_BITS-1:0]   rr_ptr;

  logic [CHAN_BITS-1:0]   cmd_chan;
  logic [REM_BITS-1:0]    cmd_chunk;
  logic [BLEN_BITS-1:0]   cmd_len;
  logic                   cmd_last;

  logic                   grant_found;
  logic [CHAN_BITS-1:0]   grant_idx;
  logic [REM_BITS-1:0]    grant_rem;
  logic [REM_BITS-1:0]    arb_chunk;
  logic                   arb_last;
  logic                   issue_done;
  int                     scan_idx;

  // Ready is forced low while reset is held, then follows the holding registers.
  assign req_ready  = ~hv & {N_SPLIT_CHAN{aresetn}};
  assign issue_done = (state == ST_ISSUE) && mux.ready;

  assign mux.valid = (state == ST_ISSUE);
  assign mux.data  = {cmd_chan, cmd_len, cmd_last};

  always_comb begin
    for (int i = 0; i < N_SPLIT_CHAN; i++) begin
      ceil_beats[i] = REM_BITS'(({1'b0, req_len[i]} + (LEN_BITS + 1)'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_ARB;
    end else begin
      state <= next_state;
    end
  end

  // Scan from rr_ptr so the channel after the last grant gets first chance.
  always_comb begin
    next_state  = state;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < N_SPLIT_CHAN; k++) begin
      scan_idx = (int'(rr_ptr) + k) % N_SPLIT_CHAN;
      if (!grant_found && hv[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_BITS'(scan_idx);
      end
    end
    grant_rem = rem[grant_idx];
`ifdef MUX_SCHED_SPLIT_EN
    arb_chunk = (grant_rem > MAX_BEATS) ? MAX_BEATS : grant_rem;
    arb_last  = lst[grant_idx] && (grant_rem <= MAX_BEATS);
`else
    arb_chunk = grant_rem;
    arb_last  = lst[grant_idx];
`endif
    case (state)
      ST_ARB:   if (grant_found) next_state = ST_ISSUE;
      ST_ISSUE: if (mux.ready) next_state = ST_ARB;
      default:  next_state = ST_ARB;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cmd_chan  <= '0;
      cmd_chunk <= '0;
      cmd_len   <= '0;
      cmd_last  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (state == ST_ARB && grant_found) begin
        cmd_chan  <= grant_idx;
        cmd_chunk <= arb_chunk;
        cmd_len   <= BLEN_BITS'(arb_chunk - 1'b1);
        cmd_last  <= arb_last;
      end
      if (issue_done) begin
        rr_ptr <= (int'(cmd_chan) == N_SPLIT_CHAN - 1) ? '0 : cmd_chan + 1'b1;
      end
    end
  end

  // A granted channel never has ready high, so issue and accept cannot collide on it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hv  <= '0;
      lst <= '0;
      for (int i = 0; i < N_SPLIT_CHAN; i++) rem[i] <= '0;
    end else begin
      for (int i = 0; i < N_SPLIT_CHAN; i++) begin
        if (issue_done && cmd_chan == CHAN_BITS'(i)) begin
          rem[i] <= rem[i] - cmd_chunk;
          if (rem[i] == cmd_chunk) hv[i] <= 1'b0;
        end else if (req_valid[i] && req_ready[i]) begin
          rem[i] <= ceil_beats[i];
          hv[i]  <= (ceil_beats[i] != '0);
          lst[i] <= req_last[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_mux_dma_sink_sched.sv
// Directed bench for axis_mux_dma_sink_sched: 4 channels, 64 B beats, 4096 B bursts.
// Expected commands follow MUX_SCHED_SPLIT_EN, matching however the RTL was built.
module tb_axis_mux_dma_sink_sched;
  logic             aclk;
  logic             aresetn;
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [3:0][15:0] req_len;
  wire  [3:0]       req_ready;

  int checks = 0;
  int errors = 0;

  muxIntf #(.CHAN_BITS(2), .BLEN_BITS(10)) mux_if ();

  axis_mux_dma_sink_sched #(
    .N_SPLIT_CHAN(4), .MUX_DATA_BITS(512), .MAX_BURST_BYTES(4096), .LEN_BITS(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_last(req_last), .mux(mux_if.m)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_req(input int ch, input int len, input bit last);
    req_valid[ch] = 1'b1;
    req_len[ch]   = 16'(len);
    req_last[ch]  = last;
    tick();
    req_valid[ch] = 1'b0;
  endtask

  // Waits (bounded) for a command, records it and completes the handshake.
  task automatic get_cmd(output bit got, output logic [1:0] c, output logic [9:0] l, output logic la);
    for (int i = 0; i < 20 && mux_if.valid !== 1'b1; i++) tick();
    got = (mux_if.valid === 1'b1);
    c   = mux_if.data.chan;
    l   = mux_if.data.len;
    la  = mux_if.data.last;
    if (got) begin
      mux_if.ready = 1'b1;
      tick();
      mux_if.ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (mux_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", mux_if.valid); end
    checks++;
    if (req_ready !== 4'h0) begin errors++; $display("[TB] FAIL reset_ready_low: got %h want 0", req_ready); end
    checks++;
    if (mux_if.data !== 13'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", mux_if.data); end
    aresetn = 1'b1;
    tick();
    checks++;
    if (req_ready !== 4'hF) begin errors++; $display("[TB] FAIL reset_ready_release: got %h want f", req_ready); end
    checks++;
    if (mux_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid: got %b want 0", mux_if.valid); end
  endtask

  task automatic test_single();
    send_req(2, 256, 1'b1);
    checks++;
    if (mux_if.valid !== 1'b0 || req_ready[2] !== 1'b0) begin
      errors++; $display("[TB] FAIL single_t1: valid %b ready2 %b want 0 0", mux_if.valid, req_ready[2]);
    end
    tick();
    checks++;
    if ({mux_if.valid, mux_if.data} !== {1'b1, 2'd2, 10'd3, 1'b1}) begin
      errors++; $display("[TB] FAIL single_cmd: got v%b %h want v1 %h", mux_if.valid, mux_if.data, {2'd2, 10'd3, 1'b1});
    end
    mux_if.ready = 1'b1;
    tick();
    mux_if.ready = 1'b0;
    checks++;
    if (req_ready[2] !== 1'b1 || mux_if.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_after: ready2 %b valid %b want 1 0", req_ready[2], mux_if.valid);
    end
  endtask

  task automatic test_rounding();
    bit got; logic [1:0] c; logic [9:0] l; logic la; bit seen;
    send_req(0, 100, 1'b0);
    get_cmd(got, c, l, la);
    checks++;
    if (!got || c !== 2'd0 || l !== 10'd1 || la !== 1'b0) begin
      errors++; $display("[TB] FAIL round_100: got %b ch %0d len %0d last %b want 1 0 1 0", got, c, l, la);
    end
    send_req(0, 0, 1'b1);
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready: got %b want 1", req_ready[0]); end
    seen = 1'b0;
    repeat (4) begin tick(); if (mux_if.valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL zero_no_cmd: valid seen %b want 0", seen); end
  endtask

  task automatic test_split();
    bit got; logic [1:0] c; logic [9:0] l; logic la; bit seen;
`ifdef MUX_SCHED_SPLIT_EN
    int n = 3;
    int exp_len [3] = '{63, 63, 28};
    bit exp_last [3] = '{1'b0, 1'b0, 1'b1};
`else
    int n = 1;
    int exp_len [1] = '{156};
    bit exp_last [1] = '{1'b1};
`endif
    send_req(1, 10000, 1'b1);
    for (int k = 0; k < n; k++) begin
      get_cmd(got, c, l, la);
      checks++;
      if (!got || c !== 2'd1 || l !== 10'(exp_len[k]) || la !== exp_last[k]) begin
        errors++;
        $display("[TB] FAIL split_%0d: got %b ch %0d len %0d last %b want 1 1 %0d %b", k, got, c, l, la, exp_len[k], exp_last[k]);
      end
    end
    seen = 1'b0;
    repeat (4) begin tick(); if (mux_if.valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL split_end: extra %b ready1 %b want 0 1", seen, req_ready[1]);
    end
  endtask

  task automatic test_round_robin();
    bit got; logic [1:0] c; logic [9:0] l; logic la;
`ifdef MUX_SCHED_SPLIT_EN
    int n = 4;
    int exp_ch [4] = '{0, 3, 0, 3};
    int exp_len [4] = '{63, 63, 63, 63};
    bit exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    int n = 2;
    int exp_ch [2] = '{0, 3};
    int exp_len [2] = '{127, 127};
    bit exp_last [2] = '{1'b1, 1'b1};
`endif
    do_reset();
    req_valid[0] = 1'b1; req_len[0] = 16'd8192; req_last[0] = 1'b1;
    req_valid[3] = 1'b1; req_len[3] = 16'd8192; req_last[3] = 1'b1;
    tick();
    req_valid = 4'h0;
    for (int k = 0; k < n; k++) begin
      get_cmd(got, c, l, la);
      checks++;
      if (!got || c !== 2'(exp_ch[k]) || l !== 10'(exp_len[k]) || la !== exp_last[k]) begin
        errors++;
        $display("[TB] FAIL rr_%0d: got %b ch %0d len %0d last %b want 1 %0d %0d %b", k, got, c, l, la, exp_ch[k], exp_len[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit got; logic [1:0] c; logic [9:0] l; logic la;
    logic [12:0] held;
    send_req(1, 128, 1'b1);
    for (int i = 0; i < 20 && mux_if.valid !== 1'b1; i++) tick();
    held = mux_if.data;
    checks++;
    if (mux_if.valid !== 1'b1 || held !== {2'd1, 10'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL bp_cmd: valid %b data %h want 1 %h", mux_if.valid, held, {2'd1, 10'd1, 1'b1});
    end
    req_valid[2] = 1'b1; req_len[2] = 16'd64; req_last[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_valid[2] = 1'b0;
      checks++;
      if (mux_if.valid !== 1'b1 || mux_if.data !== held || req_ready[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: valid %b data %h ready1 %b want 1 %h 0", i, mux_if.valid, mux_if.data, req_ready[1], held);
      end
    end
    checks++;
    if (req_ready[2] !== 1'b0) begin errors++; $display("[TB] FAIL bp_side_accept: ready2 %b want 0", req_ready[2]); end
    mux_if.ready = 1'b1;
    tick();
    mux_if.ready = 1'b0;
    get_cmd(got, c, l, la);
    checks++;
    if (!got || c !== 2'd2 || l !== 10'd0 || la !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_next: got %b ch %0d len %0d last %b want 1 2 0 1", got, c, l, la);
    end
  endtask

  task automatic test_reset_mid();
    bit got; logic [1:0] c; logic [9:0] l; logic la; bit seen;
    send_req(3, 64, 1'b1);
    for (int i = 0; i < 20 && mux_if.valid !== 1'b1; i++) tick();
    checks++;
    if (mux_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending: valid %b want 1", mux_if.valid); end
    aresetn = 1'b0;
    tick();
    checks++;
    if (mux_if.valid !== 1'b0 || req_ready !== 4'h0) begin
      errors++; $display("[TB] FAIL mid_reset: valid %b ready %h want 0 0", mux_if.valid, req_ready);
    end
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (4) begin tick(); if (mux_if.valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || req_ready !== 4'hF) begin
      errors++; $display("[TB] FAIL mid_dropped: cmd seen %b ready %h want 0 f", seen, req_ready);
    end
    req_valid[0] = 1'b1; req_len[0] = 16'd64; req_last[0] = 1'b1;
    req_valid[3] = 1'b1; req_len[3] = 16'd64; req_last[3] = 1'b0;
    tick();
    req_valid = 4'h0;
    get_cmd(got, c, l, la);
    checks++;
    if (!got || c !== 2'd0 || l !== 10'd0 || la !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_first: got %b ch %0d len %0d last %b want 1 0 0 1", got, c, l, la);
    end
    get_cmd(got, c, l, la);
    checks++;
    if (!got || c !== 2'd3 || l !== 10'd0 || la !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_second: got %b ch %0d len %0d last %b want 1 3 0 0", got, c, l, la);
    end
  endtask

  initial begin
    aresetn      = 1'b0;
    req_valid    = 4'h0;
    req_last     = 4'h0;
    req_len      = '0;
    mux_if.ready = 1'b0;
    test_reset();
    test_single();
    test_rounding();
    test_split();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
